// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: operand/opcode widths,
// the buffered instruction payload and the result-register state encoding.
package alu_pkg;

  localparam int ALU_W   = 4;
  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] OP_NOP = 4'b1111;

  typedef struct packed {
    logic [ALU_OPW-1:0] opcode;
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
  } alu_instr_t;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with registered occupancy. A push while full and a
// pop while empty are both ignored.
module sync_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_instr_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            full_s;
  logic            empty_s;
  logic            do_push_s;
  logic            do_pop_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == CW'(0));
  assign do_push_s = push && !full_s;
  assign do_pop_s  = pop && !empty_s;

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

  // Storage array; cleared on reset so the head never exposes stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Read/write pointers, wrapping DEPTH-1 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? AW'(0) : wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? AW'(0) : rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: queues instructions, feeds
// the FIFO head to the ALU and registers its result behind a valid/ready pair.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W,
  parameter int OPW   = ALU_OPW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_opcode,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic [OPW-1:0]           alu_opcode,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  input  logic [W-1:0]             alu_out,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic                     res_carry,
  output logic [OPW-1:0]           res_opcode,
  output logic [$clog2(DEPTH):0]   count
);

  alu_instr_t  wr_instr_s;
  alu_instr_t  head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        capture_s;
  res_state_t  res_state_r;
  res_state_t  res_state_nxt_s;
  logic [W-1:0]   res_data_r;
  logic           res_carry_r;
  logic [OPW-1:0] res_opcode_r;

  assign wr_instr_s = '{opcode: in_opcode, a: in_a, b: in_b};

  // in_ready comes only from registered occupancy, never from res_ready.
  assign in_ready  = !fifo_full_s;
  assign push_s    = in_valid && !fifo_full_s;
  assign res_valid = (res_state_r == RES_FULL);
  assign capture_s = !fifo_empty_s && (!res_valid || res_ready);

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_instr_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (wr_instr_s),
    .pop   (capture_s),
    .head  (head_s),
    .count (count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // ALU-facing mux: present the head, or a NOP with zero operands when empty.
  always_comb begin
    alu_opcode = OP_NOP;
    alu_a      = '0;
    alu_b      = '0;
    if (!fifo_empty_s) begin
      alu_opcode = head_s.opcode;
      alu_a      = head_s.a;
      alu_b      = head_s.b;
    end else begin
      alu_opcode = OP_NOP;
      alu_a      = '0;
      alu_b      = '0;
    end
  end

  // Result-register state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_state_r <= RES_EMPTY;
    end else begin
      res_state_r <= res_state_nxt_s;
    end
  end

  // Result-register next state; a capture always refills, otherwise a consume drains.
  always_comb begin
    res_state_nxt_s = res_state_r;
    case (res_state_r)
      RES_EMPTY: begin
        if (capture_s) begin
          res_state_nxt_s = RES_FULL;
        end else begin
          res_state_nxt_s = RES_EMPTY;
        end
      end
      RES_FULL: begin
        if (capture_s) begin
          res_state_nxt_s = RES_FULL;
        end else if (res_ready) begin
          res_state_nxt_s = RES_EMPTY;
        end else begin
          res_state_nxt_s = RES_FULL;
        end
      end
      default: res_state_nxt_s = RES_EMPTY;
    endcase
  end

  // Result payload; holds its last value once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_r   <= '0;
      res_carry_r  <= 1'b0;
      res_opcode_r <= OP_NOP;
    end else if (capture_s) begin
      res_data_r   <= alu_out;
      res_carry_r  <= alu_carry;
      res_opcode_r <= head_s.opcode;
    end else begin
      res_data_r   <= res_data_r;
      res_carry_r  <= res_carry_r;
      res_opcode_r <= res_opcode_r;
    end
  end

  assign res_data   = res_data_r;
  assign res_carry  = res_carry_r;
  assign res_opcode = res_opcode_r;

endmodule
